// File: rtl/tri_raster_engine.sv
// Triangle rasterizer: clips the bounding box to the screen, walks it in raster order with
// incremental edge functions and streams one framebuffer address per covered pixel.
module tri_raster_engine #(
    parameter int COORD_W  = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 26
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic signed [COORD_W-1:0] x3,
    input  logic signed [COORD_W-1:0] y3,
    input  logic [ADDR_W-1:0]         fb_base,
    output logic                      busy,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [15:0]               pix_x,
    output logic [15:0]               pix_y,
    output logic [ADDR_W-1:0]         pix_addr,
    output logic                      done,
    output logic                      degenerate
);
    localparam int CW = COORD_W + 1;
    localparam int EW = 2 * COORD_W + 3;
    localparam logic signed [CW-1:0] X_MAX  = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] Y_MAX  = CW'(SCREEN_H - 1);
    localparam logic signed [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic signed [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};
    localparam logic [ADDR_W-1:0]    PITCH  = ADDR_W'(SCREEN_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP0 = 3'd1,
        S_SETUP1 = 3'd2,
        S_SCAN   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic signed [CW-1:0] sx(input logic signed [COORD_W-1:0] v);
        return {v[COORD_W-1], v};
    endfunction

    function automatic logic signed [CW-1:0] clamp(input logic signed [CW-1:0] v,
                                                   input logic signed [CW-1:0] hi);
        if (v < ZERO_C) return ZERO_C;
        else if (v > hi) return hi;
        else return v;
    endfunction

    function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a, b, c);
        logic signed [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a, b, c);
        logic signed [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Edge function value at (x,y) for the edge starting at (xa,ya) with deltas (ex,ey)
    function automatic logic signed [EW-1:0] edge_val(input logic signed [CW-1:0] x, y, xa, ya, ex, ey);
        logic signed [EW-1:0] dx, dy;
        dx = EW'(x) - EW'(xa);
        dy = EW'(y) - EW'(ya);
        return dx * EW'(ey) - dy * EW'(ex);
    endfunction

    state_t state_r, next_state_s;
    logic signed [CW-1:0] vx_r [3];
    logic signed [CW-1:0] vy_r [3];
    logic signed [CW-1:0] ex_r [3];
    logic signed [CW-1:0] ey_r [3];
    logic signed [EW-1:0] e_r [3];
    logic signed [EW-1:0] row_e_r [3];
    logic signed [EW-1:0] area_r;
    logic signed [CW-1:0] min_x_r, max_x_r, min_y_r, max_y_r, cx_r, cy_r;
    logic [ADDR_W-1:0]    base_r, row_base_r, pix_addr_r;
    logic [15:0]          pix_x_r, pix_y_r;
    logic                 last_r, busy_r, done_r, degen_r, pix_valid_r;
    logic                 advance_s, eval_s, inside_s, empty_s;

    // Candidate evaluation: scan may advance when the output register is free or draining
    always_comb begin
        advance_s = ~pix_valid_r | pix_ready;
        eval_s    = 1'b0;
        inside_s  = 1'b0;
        empty_s   = (max_x_r < min_x_r) || (max_y_r < min_y_r);
        if ((state_r == S_SCAN) && !last_r && advance_s) eval_s = 1'b1;
        else eval_s = 1'b0;
        if (area_r[EW-1]) inside_s = (e_r[0] <= E_ZERO) && (e_r[1] <= E_ZERO) && (e_r[2] <= E_ZERO);
        else inside_s = (e_r[0] >= E_ZERO) && (e_r[1] >= E_ZERO) && (e_r[2] >= E_ZERO);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:   if (start) next_state_s = S_SETUP0; else next_state_s = S_IDLE;
            S_SETUP0: next_state_s = S_SETUP1;
            S_SETUP1: if ((area_r == E_ZERO) || empty_s) next_state_s = S_DONE; else next_state_s = S_SCAN;
            S_SCAN:   if (last_r && advance_s) next_state_s = S_DONE; else next_state_s = S_SCAN;
            S_DONE:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= next_state_s;
    end

    // Setup and scan datapath: vertex latch, bbox, edge deltas and incremental edge walk
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                vx_r[k] <= ZERO_C; vy_r[k] <= ZERO_C; ex_r[k] <= ZERO_C; ey_r[k] <= ZERO_C;
                e_r[k]  <= E_ZERO; row_e_r[k] <= E_ZERO;
            end
            area_r  <= E_ZERO;
            min_x_r <= ZERO_C; max_x_r <= ZERO_C; min_y_r <= ZERO_C; max_y_r <= ZERO_C;
            cx_r    <= ZERO_C; cy_r <= ZERO_C;
            base_r  <= {ADDR_W{1'b0}}; row_base_r <= {ADDR_W{1'b0}};
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        vx_r[0] <= sx(x1); vy_r[0] <= sx(y1);
                        vx_r[1] <= sx(x2); vy_r[1] <= sx(y2);
                        vx_r[2] <= sx(x3); vy_r[2] <= sx(y3);
                        base_r  <= fb_base;
                    end
                end
                S_SETUP0: begin
                    min_x_r <= clamp(min3(vx_r[0], vx_r[1], vx_r[2]), X_MAX);
                    max_x_r <= clamp(max3(vx_r[0], vx_r[1], vx_r[2]), X_MAX);
                    min_y_r <= clamp(min3(vy_r[0], vy_r[1], vy_r[2]), Y_MAX);
                    max_y_r <= clamp(max3(vy_r[0], vy_r[1], vy_r[2]), Y_MAX);
                    ex_r[0] <= vx_r[1] - vx_r[0]; ey_r[0] <= vy_r[1] - vy_r[0];
                    ex_r[1] <= vx_r[2] - vx_r[1]; ey_r[1] <= vy_r[2] - vy_r[1];
                    ex_r[2] <= vx_r[0] - vx_r[2]; ey_r[2] <= vy_r[0] - vy_r[2];
                    area_r  <= edge_val(vx_r[2], vy_r[2], vx_r[0], vy_r[0],
                                        vx_r[1] - vx_r[0], vy_r[1] - vy_r[0]);
                end
                S_SETUP1: begin
                    // Edge k starts at vertex k, so E12/E23/E31 map to k = 0/1/2
                    for (int k = 0; k < 3; k++) begin
                        e_r[k]     <= edge_val(min_x_r, min_y_r, vx_r[k], vy_r[k], ex_r[k], ey_r[k]);
                        row_e_r[k] <= edge_val(min_x_r, min_y_r, vx_r[k], vy_r[k], ex_r[k], ey_r[k]);
                    end
                    cx_r       <= min_x_r;
                    cy_r       <= min_y_r;
                    row_base_r <= base_r + ADDR_W'($unsigned(min_y_r)) * PITCH;
                    last_r     <= 1'b0;
                end
                S_SCAN: begin
                    if (eval_s) begin
                        if (cx_r == max_x_r) begin
                            if (cy_r == max_y_r) begin
                                last_r <= 1'b1;
                            end else begin
                                cx_r       <= min_x_r;
                                cy_r       <= cy_r + ONE_C;
                                row_base_r <= row_base_r + PITCH;
                                for (int k = 0; k < 3; k++) begin
                                    row_e_r[k] <= row_e_r[k] - EW'(ex_r[k]);
                                    e_r[k]     <= row_e_r[k] - EW'(ex_r[k]);
                                end
                            end
                        end else begin
                            cx_r <= cx_r + ONE_C;
                            for (int k = 0; k < 3; k++) e_r[k] <= e_r[k] + EW'(ey_r[k]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status and pixel output stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            degen_r     <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_x_r     <= 16'd0;
            pix_y_r     <= 16'd0;
            pix_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            busy_r <= (next_state_s == S_SETUP0) || (next_state_s == S_SETUP1) || (next_state_s == S_SCAN);
            done_r <= (next_state_s == S_DONE);
            if ((state_r == S_IDLE) && start) degen_r <= 1'b0;
            else if ((state_r == S_SETUP1) && (area_r == E_ZERO)) degen_r <= 1'b1;
            if (eval_s && inside_s) begin
                pix_valid_r <= 1'b1;
                pix_x_r     <= 16'($unsigned(cx_r));
                pix_y_r     <= 16'($unsigned(cy_r));
                pix_addr_r  <= row_base_r + ADDR_W'($unsigned(cx_r));
            end else if (advance_s) begin
                pix_valid_r <= 1'b0;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign degenerate = degen_r;
    assign pix_valid  = pix_valid_r;
    assign pix_x      = pix_x_r;
    assign pix_y      = pix_y_r;
    assign pix_addr   = pix_addr_r;
endmodule
